tbl_lookup_stage: RTL
=====================

Name: tbl_lookup_stage

Overview:
- Read-side front end for a single-read-port table SRAM (simple dual-port, 1-cycle registered read, read port has no enable gating).
- Accepts lookup requests (address + opaque tag) over a valid/ready handshake and drives the SRAM read address.
- Captures the read data one cycle later and returns {tag, data} in order through a small response FIFO with full backpressure.
- Sits between the key-extractor stage and the action stage of each pipeline stage.

Parameters:
- DATA_WIDTH, 8, SRAM word width.
- ADDR_WIDTH, 4, SRAM address width.
- TAG_WIDTH, 8, opaque request tag width carried alongside the lookup.
- RSP_DEPTH, 4, response FIFO entries; legal range 2..16. Values ≥3 give full throughput.

Ports:
- clk  in  1  single clock for all logic.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  1  lookup request valid.
- req_ready  out  1  request accepted when high with req_valid.
- req_addr  in  ADDR_WIDTH  table index.
- req_tag  in  TAG_WIDTH  opaque tag returned with the result.
- ram_addr  out  ADDR_WIDTH  to SRAM read address.
- ram_en  out  1  to SRAM read enable; informational, SRAM reads every cycle.
- ram_dout  in  DATA_WIDTH  SRAM registered read data.
- wr_en  in  1  snoop of SRAM write enable.
- wr_addr  in  ADDR_WIDTH  snoop of SRAM write address.
- wr_data  in  DATA_WIDTH  snoop of SRAM write data.
- rsp_valid  out  1  result valid.
- rsp_ready  in  1  downstream accept.
- rsp_data  out  DATA_WIDTH  looked-up word.
- rsp_tag  out  TAG_WIDTH  tag of the request.

Behaviour:
- Reset (synchronous, rst=1 at posedge): FIFO emptied, inflight=0, count=0. rsp_valid=0, req_ready=0, ram_en=0, rsp_data=0, rsp_tag=0.
- Flow control:
  - req_ready = !rst && (count + inflight < RSP_DEPTH), derived from registers only; never depends on rsp_ready combinationally.
  - fire = req_valid && req_ready.
- Address path: ram_addr = req_addr (combinational pass-through); ram_en = fire.
- Issue cycle N (fire): inflight<=1, tag_q<=req_tag. No fire: inflight<=0.
- Cycle N+1: ram_dout holds the word. If inflight=1, push {tag_q, ram_dout} into the FIFO at end of N+1.
- Latency: rsp_valid is high in cycle N+2 when the FIFO was empty; fire-to-response = 2 cycles.
- Throughput: back-to-back fires every cycle when rsp_ready=1 and RSP_DEPTH≥3.
- Output: rsp_valid = (count≠0); rsp_data/rsp_tag show the FIFO head. Pop on rsp_valid && rsp_ready. Outputs are stable while rsp_valid && !rsp_ready.
- Push and pop in the same cycle: count unchanged. The push path never overflows because inflight is reserved at issue.
- FIFO pointers wrap modulo RSP_DEPTH. count width is clog2(RSP_DEPTH+1).
- Ordering: strictly in issue order; no reordering and no drops.
- Reset mid-operation: in-flight and buffered results are discarded. No response is emitted for them.
- Read-during-write: the SRAM returns the old word when a write to the same address lands in the issue cycle. A write in cycle N+1 does not affect the result.

Optional Feature:
- Macro TBL_LOOKUP_WR_FWD_EN.
- Defined: on fire, if wr_en && wr_addr==req_addr, register fwd_hit=1 and fwd_data=wr_data. In N+1, push fwd_data instead of ram_dout. Result is new-data read-after-write.
- Undefined: wr_* ports are present but ignored. Old-data semantics as above.

Decomposition:
- Package tbl_lookup_pkg: width constants and the rsp_entry_t struct {tag, data}.
- Sub-module tbl_rsp_fifo: synchronous FIFO of rsp_entry_t with RSP_DEPTH entries. Ports: push, pop, count, head. Synchronous reset.
- Issue/capture/forward logic stays in the top module.

Test Plan:
- Reset then idle: rst held 3 cycles → req_ready=0, rsp_valid=0 during reset; req_ready=1 on the first cycle after.
- Single lookup: RAM[5]=0xA5, fire addr=5 tag=0x11 at cycle N → rsp_valid at N+2 with rsp_data=0xA5, rsp_tag=0x11; ram_en=1 only in cycle N.
- Streaming: 16 back-to-back requests addr 0..15, rsp_ready=1, RSP_DEPTH=4 → 16 responses on consecutive cycles, in order, tags 0..15.
- Backpressure: rsp_ready=0 while issuing → exactly 4 accepted, then req_ready=0. Raising rsp_ready drains 4 in order and req_ready returns 1 one cycle after the first pop.
- Collision: RAM[3]=0x10; same cycle wr_en addr=3 data=0x77 and fire addr=3 → response 0x10 without macro, 0x77 with TBL_LOOKUP_WR_FWD_EN; a subsequent lookup returns 0x77 in both builds.
- Reset mid-stream: rst for 1 cycle with 3 results buffered and 1 in flight → no responses afterwards; the next request returns correct data with 2-cycle latency.

Source files
------------

// File: rtl/tbl_lookup_pkg.sv
// Shared widths and the response entry type for the table lookup stage.
package tbl_lookup_pkg;

  localparam int TBL_DATA_WIDTH = 8;
  localparam int TBL_ADDR_WIDTH = 4;
  localparam int TBL_TAG_WIDTH  = 8;
  localparam int TBL_RSP_DEPTH  = 4;

  typedef struct packed {
    logic [TBL_TAG_WIDTH-1:0]  tag;
    logic [TBL_DATA_WIDTH-1:0] data;
  } rsp_entry_t;

endpackage

// File: rtl/tbl_rsp_fifo.sv
// In-order response FIFO of rsp_entry_t; pointers wrap modulo DEPTH so any
// depth in 2..16 is legal.
module tbl_rsp_fifo
  import tbl_lookup_pkg::*;
#(
  parameter int DEPTH = TBL_RSP_DEPTH
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  rsp_entry_t                 push_entry,
  input  logic                       pop,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output rsp_entry_t                 head
);

  localparam int CW = $clog2(DEPTH+1);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  rsp_entry_t    mem_r [DEPTH];
  logic [PW-1:0] wr_ptr_r;
  logic [PW-1:0] rd_ptr_r;
  logic [CW-1:0] count_r;
  logic          push_s;
  logic          pop_s;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    if (p == PW'(DEPTH-1)) begin
      return '0;
    end else begin
      return p + PW'(1);
    end
  endfunction

  // Defensive guards: never write when full or read when empty.
  assign push_s = push && (count_r != CW'(DEPTH));
  assign pop_s  = pop && (count_r != '0);

  // Entry storage; cleared on reset so an empty FIFO presents zeros.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= '0;
      end
    end else if (push_s) begin
      mem_r[wr_ptr_r] <= push_entry;
    end
  end

  // Read/write pointers and occupancy count.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
    end else begin
      if (push_s) begin
        wr_ptr_r <= ptr_inc(wr_ptr_r);
      end
      if (pop_s) begin
        rd_ptr_r <= ptr_inc(rd_ptr_r);
      end
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + CW'(1);
        2'b01:   count_r <= count_r - CW'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  assign count = count_r;
  assign head  = mem_r[rd_ptr_r];

endmodule

// File: rtl/tbl_lookup_stage.sv
// Read-side front end for a 1-cycle registered-read table SRAM; returns {tag, data}
// in issue order. Define TBL_LOOKUP_WR_FWD_EN for read-after-write forwarding.
module tbl_lookup_stage
  import tbl_lookup_pkg::*;
#(
  parameter int DATA_WIDTH = TBL_DATA_WIDTH,
  parameter int ADDR_WIDTH = TBL_ADDR_WIDTH,
  parameter int TAG_WIDTH  = TBL_TAG_WIDTH,
  parameter int RSP_DEPTH  = TBL_RSP_DEPTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [TAG_WIDTH-1:0]  req_tag,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic                  ram_en,
  input  logic [DATA_WIDTH-1:0] ram_dout,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_data,
  output logic [TAG_WIDTH-1:0]  rsp_tag
);

  localparam int              CW        = $clog2(RSP_DEPTH+1);
  localparam logic [CW:0]     DEPTH_LIM = (CW+1)'(RSP_DEPTH);

  logic                  fire_s;
  logic                  req_ready_s;
  logic                  pop_s;
  logic                  inflight_r;
  logic [TAG_WIDTH-1:0]  tag_r;
  logic [CW-1:0]         count_s;
  logic [CW:0]           outstanding_s;
  logic [DATA_WIDTH-1:0] lookup_data_s;
  rsp_entry_t            push_entry_s;
  rsp_entry_t            head_s;

  // A FIFO slot is reserved at issue, so the capture push can never overflow.
  assign outstanding_s = {1'b0, count_s} + {{CW{1'b0}}, inflight_r};
  assign req_ready_s   = !rst && (outstanding_s < DEPTH_LIM);
  assign fire_s        = req_valid && req_ready_s;

  assign req_ready = req_ready_s;
  assign ram_addr  = req_addr;
  assign ram_en    = fire_s;

  // Issue-cycle capture of the in-flight flag and the request tag.
  always_ff @(posedge clk) begin
    if (rst) begin
      inflight_r <= 1'b0;
      tag_r      <= '0;
    end else begin
      inflight_r <= fire_s;
      if (fire_s) begin
        tag_r <= req_tag;
      end
    end
  end

`ifdef TBL_LOOKUP_WR_FWD_EN
  logic                  fwd_hit_r;
  logic [DATA_WIDTH-1:0] fwd_data_r;

  // Remember a same-cycle write to the looked-up address so the new word wins.
  always_ff @(posedge clk) begin
    if (rst) begin
      fwd_hit_r  <= 1'b0;
      fwd_data_r <= '0;
    end else if (fire_s) begin
      fwd_hit_r  <= wr_en && (wr_addr == req_addr);
      fwd_data_r <= wr_data;
    end else begin
      fwd_hit_r  <= 1'b0;
    end
  end

  // Select forwarded write data over the SRAM's old word.
  always_comb begin
    lookup_data_s = ram_dout;
    if (fwd_hit_r) begin
      lookup_data_s = fwd_data_r;
    end else begin
      lookup_data_s = ram_dout;
    end
  end
`else
  logic unused_wr_s;
  assign unused_wr_s   = ^{wr_en, wr_addr, wr_data};
  assign lookup_data_s = ram_dout;
`endif

  assign push_entry_s.tag  = tag_r;
  assign push_entry_s.data = lookup_data_s;
  assign pop_s             = rsp_valid && rsp_ready;

  tbl_rsp_fifo #(
    .DEPTH (RSP_DEPTH)
  ) u_rsp_fifo (
    .clk        (clk),
    .rst        (rst),
    .push       (inflight_r),
    .push_entry (push_entry_s),
    .pop        (pop_s),
    .count      (count_s),
    .head       (head_s)
  );

  assign rsp_valid = (count_s != '0);
  assign rsp_data  = head_s.data;
  assign rsp_tag   = head_s.tag;

endmodule
